// File: rtl/sv32_ptw_lite_pkg.sv
// Shared Sv32 MMU types for the page-table walker.
// PTE layout, walk constants and walker state encodings.
package sv32_ptw_lite_pkg;

    localparam int VLEN        = 32;
    localparam int PLEN        = 34;
    localparam int PPN_W       = 22;
    localparam int SV32_LEVELS = 2;
    localparam int PTESIZE     = 4;

    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } sv32_pte_t;

    typedef logic [2:0] ptw_state_e;

    localparam ptw_state_e S_IDLE    = 3'd0;
    localparam ptw_state_e S_L1_REQ  = 3'd1;
    localparam ptw_state_e S_L1_WAIT = 3'd2;
    localparam ptw_state_e S_L0_REQ  = 3'd3;
    localparam ptw_state_e S_L0_WAIT = 3'd4;
    localparam ptw_state_e S_RESP    = 3'd5;
    localparam ptw_state_e S_DRAIN   = 3'd6;

endpackage

// File: rtl/sv32_ptw_lite.sv
// Sv32 hardware page-table walker, one TLB miss at a time.
// Single outstanding PTE read; returns leaf PTE or page/access fault.
module sv32_ptw_lite
    import sv32_ptw_lite_pkg::*;
#(
    parameter int CHK_LEVEL = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [PPN_W-1:0] satp_ppn_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [VLEN-1:0]  req_vaddr_i,
    input  logic             req_store_i,
    output logic             mem_req_o,
    input  logic             mem_gnt_i,
    output logic [PLEN-1:0]  mem_addr_o,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
    input  logic             mem_err_i,
    input  logic             pma_cached_i,
    output logic             rsp_valid_o,
    output logic [19:0]      rsp_vpn_o,
    output logic [PPN_W-1:0] rsp_ppn_o,
    output logic             rsp_super_o,
    output logic [7:0]       rsp_flags_o,
    output logic             rsp_pf_o,
    output logic             rsp_af_o
);

    ptw_state_e       state;
    logic [19:0]      vpn_q;
    logic             store_q;
    logic [PPN_W-1:0] satp_q;
    logic [PPN_W-1:0] ptr_q;
    logic             af_q;

    sv32_pte_t pte;
    logic      level1;
    logic      leaf;
    logic      res_af;
    logic      res_pf;
    logic      go_l0;
    logic      unused_bits;

    assign pte         = sv32_pte_t'(mem_rdata_i);
    assign level1      = (state == S_L1_WAIT);
    assign leaf        = pte.r | pte.x;
    assign unused_bits = ^{pte.rsw, req_vaddr_i[11:0]};

    assign req_ready_o = (state == S_IDLE);
    assign mem_req_o   = (state == S_L1_REQ) || (state == S_L0_REQ);
    assign rsp_valid_o = (state == S_RESP) && !flush_i;
    assign rsp_vpn_o   = vpn_q;

    // PTE address: root table at level 1, pointer PPN at level 0
    always_comb begin
        mem_addr_o = '0;
        if (state == S_L1_REQ)
            mem_addr_o = {satp_q, vpn_q[19:10], 2'b00};
        else if (state == S_L0_REQ)
            mem_addr_o = {ptr_q, vpn_q[9:0], 2'b00};
    end

    // Classify the returned PTE in fault-priority order
    always_comb begin
        res_af = mem_err_i | af_q;
        res_pf = 1'b0;
        go_l0  = 1'b0;
        if (!res_af) begin
            if (!pte.v || (!pte.r && pte.w))
                res_pf = 1'b1;
            else if (leaf) begin
                if (level1 && (pte.ppn0 != 10'd0))
                    res_pf = 1'b1;
                else if (!pte.a || (store_q && !pte.d))
                    res_pf = 1'b1;
            end else if (level1)
                go_l0 = 1'b1;
            else
                res_pf = 1'b1;
        end
    end

    // Walk sequencing, request latching and result registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            vpn_q       <= '0;
            store_q     <= 1'b0;
            satp_q      <= '0;
            ptr_q       <= '0;
            af_q        <= 1'b0;
            rsp_ppn_o   <= '0;
            rsp_super_o <= 1'b0;
            rsp_flags_o <= '0;
            rsp_pf_o    <= 1'b0;
            rsp_af_o    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        vpn_q       <= req_vaddr_i[31:12];
                        store_q     <= req_store_i;
                        satp_q      <= satp_ppn_i;
                        rsp_ppn_o   <= '0;
                        rsp_super_o <= 1'b0;
                        rsp_flags_o <= '0;
                        rsp_pf_o    <= 1'b0;
                        rsp_af_o    <= 1'b0;
                        state       <= S_L1_REQ;
                    end
                end
                S_L1_REQ, S_L0_REQ: begin
                    if (mem_gnt_i) begin
                        af_q <= (CHK_LEVEL != 0) && !pma_cached_i;
                        if (flush_i)
                            state <= S_DRAIN;
                        else if (state == S_L1_REQ)
                            state <= S_L1_WAIT;
                        else
                            state <= S_L0_WAIT;
                    end else if (flush_i) begin
                        state <= S_IDLE;
                    end
                end
                S_L1_WAIT, S_L0_WAIT: begin
                    if (flush_i) begin
                        state <= mem_rvalid_i ? S_IDLE : S_DRAIN;
                    end else if (mem_rvalid_i) begin
                        if (go_l0) begin
                            ptr_q <= {pte.ppn1, pte.ppn0};
                            state <= S_L0_REQ;
                        end else begin
                            rsp_af_o    <= res_af;
                            rsp_pf_o    <= res_pf;
                            rsp_super_o <= level1 && !res_af && !res_pf;
                            rsp_flags_o <= res_af ? 8'h00 : mem_rdata_i[7:0];
                            if (res_af || res_pf)
                                rsp_ppn_o <= '0;
                            else if (level1)
                                rsp_ppn_o <= {pte.ppn1, vpn_q[9:0]};
                            else
                                rsp_ppn_o <= {pte.ppn1, pte.ppn0};
                            state <= S_RESP;
                        end
                    end
                end
                S_RESP: state <= S_IDLE;
                S_DRAIN: begin
                    if (mem_rvalid_i)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    a_rvalid_in_wait: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> (state == S_L1_WAIT || state == S_L0_WAIT ||
                          state == S_DRAIN)
    );

endmodule
